// File: rtl/hf_reader_rx_framer.sv
// hf_reader_rx_framer: HF reader receive datapath for one channel.
// ADC samples pass through a gaussian-derivative edge filter. A windowed
// peak detector turns each bit window into one demodulated bit. A frame
// FSM gates the bits into words, and the words are serialised MSB-first on
// a simple SSP link. All flops update on the falling edge of osc_clk.
// Optional build macro: HF_RX_STRENGTH_EN adds the rx_strength output and
// sends it in place of idle (all-zero) SSP words.
module hf_reader_rx_framer #(
  parameter int ADC_W       = 8,
  parameter int BIT_PERIOD  = 16,
  parameter int WORD_BITS   = 8,
  parameter int RESET_PHASE = 3,
  parameter int EOF_WINDOWS = 4
) (
  input  logic             osc_clk,
  input  logic             nrst,
  input  logic [ADC_W-1:0] adc_d,
  input  logic [2:0]       mode,
  input  logic [7:0]       threshold,
  input  logic             ssp_dout,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             pwr_hi,
  output logic             curbit,
  output logic             rx_active
`ifdef HF_RX_STRENGTH_EN
  ,
  output logic [ADC_W+2:0] rx_strength
`endif
);

  localparam int PH_W  = $clog2(BIT_PERIOD);
  localparam int CNT_W = $clog2(BIT_PERIOD * WORD_BITS);
  localparam int F_W   = ADC_W + 3;
  localparam int CMP_W = F_W + 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD * WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_PERIOD / 2);
  localparam logic [PH_W-1:0]  PH_CLOSE = PH_W'(RESET_PHASE);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BIT_PERIOD / 2);
  localparam logic [3:0]       RUN_EOF  = 4'(EOF_WINDOWS);

  typedef enum logic {ST_IDLE, ST_RX} state_t;

  logic [CNT_W-1:0]      r_cnt;
  logic [PH_W-1:0]       w_phase;
  logic                  w_close;
  logic                  r_close_d;
  logic [ADC_W-1:0]      r_p1, r_p2, r_p3, r_p4;
  logic [F_W-1:0]        w_f_raw;
  logic signed [F_W-1:0] w_f;
  logic                  w_f_pos;
  logic signed [F_W-1:0] r_fall_max, r_rise_min;
  logic signed [CMP_W-1:0] w_fm_ext, w_rm_ext, w_thr_pos, w_thr_neg;
  logic                  w_detect;
  logic                  r_curbit;
  state_t                r_state, w_state_next;
  logic [3:0]            r_run, w_run_next;
  logic                  w_listen, w_enter, w_shift_bit;
  logic [WORD_BITS-1:0]  r_word_sr, r_shift, w_load_word;
  logic                  r_ssp_clk, r_ssp_frame, r_ssp_din;
  logic                  r_mod_q;

  assign w_phase = r_cnt[PH_W-1:0];
  assign w_close = (w_phase == PH_CLOSE);

  // Word-period counter; the bit phase is its low bits.
  always_ff @(negedge osc_clk) begin
    if (!nrst) begin
      r_cnt     <= '0;
      r_close_d <= 1'b0;
    end else begin
      r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_close_d <= w_close;
    end
  end

  // Four-deep sample history feeding the edge filter.
  always_ff @(negedge osc_clk) begin
    if (!nrst) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_p3 <= '0;
      r_p4 <= '0;
    end else begin
      r_p1 <= adc_d;
      r_p2 <= r_p1;
      r_p3 <= r_p2;
      r_p4 <= r_p3;
    end
  end

  // Unsigned arithmetic at F_W bits wraps to the correct two's complement.
  assign w_f_raw = {2'b00, r_p4, 1'b0} + {3'b000, r_p3}
                 - {2'b00, adc_d, 1'b0} - {3'b000, r_p1};
  assign w_f     = $signed(w_f_raw);
  assign w_f_pos = !w_f[F_W-1] && (w_f_raw != '0);

  assign w_fm_ext  = $signed({{(CMP_W-F_W){r_fall_max[F_W-1]}}, r_fall_max});
  assign w_rm_ext  = $signed({{(CMP_W-F_W){r_rise_min[F_W-1]}}, r_rise_min});
  assign w_thr_pos = $signed({{(CMP_W-8){1'b0}}, threshold});
  assign w_thr_neg = -w_thr_pos;
  assign w_detect  = (w_fm_ext > w_thr_pos) && (w_rm_ext < w_thr_neg);

  // Track edge extremes within a window and decide the bit at window close.
  always_ff @(negedge osc_clk) begin
    if (!nrst) begin
      r_fall_max <= '0;
      r_rise_min <= '0;
      r_curbit   <= 1'b0;
    end else if (w_close) begin
      r_curbit   <= w_detect;
      r_fall_max <= '0;
      r_rise_min <= '0;
    end else if (w_f_pos) begin
      if (w_f > r_fall_max) r_fall_max <= w_f;
    end else if (w_f < r_rise_min) begin
      r_rise_min <= w_f;
    end
  end

  // Frame state register and zero-run counter.
  always_ff @(negedge osc_clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
    end
  end

  assign w_listen = (mode == 3'b000) || (mode == 3'b011);

  // Frame next-state: acts on the bit one cycle after each window close.
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    w_enter      = 1'b0;
    if (!w_listen) begin
      w_state_next = ST_IDLE;
    end else if (r_close_d) begin
      case (r_state)
        ST_IDLE: begin
          if (r_curbit) begin
            w_state_next = ST_RX;
            w_run_next   = '0;
            w_enter      = 1'b1;
          end
        end
        default: begin
          if (r_curbit) begin
            w_run_next = '0;
          end else begin
            w_run_next = r_run + 4'd1;
            if (r_run + 4'd1 == RUN_EOF) w_state_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  // The frame-starting bit is packed as well as every bit inside the frame.
  assign w_shift_bit = r_curbit && ((r_state == ST_RX) || w_enter);

  // Word assembly, MSB first.
  always_ff @(negedge osc_clk) begin
    if (!nrst) r_word_sr <= '0;
    else if (r_close_d) r_word_sr <= {r_word_sr[WORD_BITS-2:0], w_shift_bit};
  end

`ifdef HF_RX_STRENGTH_EN
  localparam int STR_CAT = F_W + WORD_BITS;
  logic [F_W-1:0]     r_strength;
  logic [F_W-1:0]     w_p2p;
  logic [STR_CAT-1:0] w_str_cat;

  assign w_p2p     = r_fall_max - r_rise_min;
  assign w_str_cat = {r_strength, {WORD_BITS{1'b0}}};

  // Peak-to-peak edge strength captured at each window close.
  always_ff @(negedge osc_clk) begin
    if (!nrst) r_strength <= '0;
    else if (w_close) r_strength <= w_p2p;
  end

  assign rx_strength = r_strength;
  assign w_load_word = (r_state == ST_RX) ? r_word_sr
                                          : w_str_cat[STR_CAT-1 -: WORD_BITS];
`else
  assign w_load_word = r_word_sr;
`endif

  // SSP clock, frame strobe and serialiser.
  always_ff @(negedge osc_clk) begin
    if (!nrst) begin
      r_ssp_clk   <= 1'b0;
      r_ssp_frame <= 1'b0;
      r_ssp_din   <= 1'b0;
      r_shift     <= '0;
    end else begin
      if (w_phase == '0) r_ssp_clk <= 1'b1;
      else if (w_phase == PH_HALF) r_ssp_clk <= 1'b0;

      if (r_cnt == '0) r_ssp_frame <= 1'b1;
      else if (r_cnt == CNT_HALF) r_ssp_frame <= 1'b0;

      if (r_cnt == CNT_LAST) begin
        r_shift <= w_load_word;
      end else if (w_phase == '0) begin
        r_ssp_din <= r_shift[WORD_BITS-1];
        r_shift   <= {r_shift[WORD_BITS-2:0], 1'b0};
      end
    end
  end

  // Reader modulation bit from the ARM.
  always_ff @(negedge osc_clk) begin
    if (!nrst) r_mod_q <= 1'b0;
    else r_mod_q <= ssp_dout;
  end

  // The carrier itself is gated here, so osc_clk appears in the logic cone.
  assign pwr_hi = osc_clk & (((mode == 3'b100) & ~r_mod_q) | (mode == 3'b011));

  assign ssp_clk   = r_ssp_clk;
  assign ssp_frame = r_ssp_frame;
  assign ssp_din   = r_ssp_din;
  assign curbit    = r_curbit;
  assign rx_active = (r_state == ST_RX);

endmodule

// File: tb/tb_hf_reader_rx_framer.sv
// Bench for hf_reader_rx_framer: randomized and directed ADC patterns,
// window-level reference model, scoreboard queues checked by a monitor.
module tb_hf_reader_rx_framer;
  localparam int ADC_W = 8;
  localparam int BP    = 16;
  localparam int WB    = 8;
  localparam int RP    = 3;
  localparam int EOFW  = 4;
  localparam int WCYC  = BP * WB;
  localparam int MAXN  = 1024;

  logic             osc_clk = 1'b0;
  logic             nrst = 1'b0;
  logic [ADC_W-1:0] adc_d = 8'd128;
  logic [2:0]       mode = 3'b011;
  logic [7:0]       threshold = 8'd20;
  logic             ssp_dout = 1'b0;
  logic             ssp_clk, ssp_frame, ssp_din, pwr_hi, curbit, rx_active;
`ifdef HF_RX_STRENGTH_EN
  logic [ADC_W+2:0] rx_strength;
`endif

  hf_reader_rx_framer #(
    .ADC_W(ADC_W), .BIT_PERIOD(BP), .WORD_BITS(WB),
    .RESET_PHASE(RP), .EOF_WINDOWS(EOFW)
  ) dut (
    .osc_clk(osc_clk), .nrst(nrst), .adc_d(adc_d), .mode(mode),
    .threshold(threshold), .ssp_dout(ssp_dout), .ssp_clk(ssp_clk),
    .ssp_frame(ssp_frame), .ssp_din(ssp_din), .pwr_hi(pwr_hi),
    .curbit(curbit), .rx_active(rx_active)
`ifdef HF_RX_STRENGTH_EN
    , .rx_strength(rx_strength)
`endif
  );

  always #5 osc_clk = ~osc_clk;

  int total = 0;
  int bad = 0;
  logic [WB-1:0] exp_words[$];
  logic [1:0]    exp_stat[$];
  int samp [0:MAXN-1];
  bit   in_reset = 1'b1;
  int   edge_cnt = 0;
  logic exp_modq = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Bench view of the active edge: reset flag, edge count, expected mod_q.
  always @(negedge osc_clk) begin
    in_reset = !nrst;
    if (!nrst) begin
      edge_cnt = 0;
      exp_modq = 1'b0;
    end else begin
      edge_cnt++;
      exp_modq = ssp_dout;
    end
  end

  // Monitor: reassembles SSP words and checks per-window status.
  bit          mon_coll = 1'b0;
  int          mon_nb = 0;
  logic [WB-1:0] mon_acc = '0;
  logic        mon_prev = 1'b0;
  always @(posedge osc_clk) begin
    if (in_reset) begin
      mon_coll = 1'b0;
      mon_nb   = 0;
      mon_prev = 1'b0;
    end else begin
      if (ssp_clk && !mon_prev && ssp_frame) begin
        mon_coll = 1'b1;
        mon_nb   = 0;
        mon_acc  = '0;
      end else if (!ssp_clk && mon_prev && mon_coll) begin
        mon_acc = {mon_acc[WB-2:0], ssp_din};
        mon_nb++;
        if (mon_nb == WB) begin
          mon_coll = 1'b0;
          if (exp_words.size() == 0) begin
            check("unexpected_word", int'(mon_acc), -1);
          end else begin
            logic [WB-1:0] ew;
            ew = exp_words.pop_front();
            $display("word got=%02h exp=%02h", mon_acc, ew);
            check("ssp_word", int'(mon_acc), int'(ew));
          end
        end
      end
      mon_prev = ssp_clk;
      if (edge_cnt > 0 && ((edge_cnt - 1) % BP) == ((RP + 1) % BP)) begin
        if (exp_stat.size() == 0) begin
          check("unexpected_status", int'({curbit, rx_active}), -1);
        end else begin
          logic [1:0] es;
          es = exp_stat.pop_front();
          check("curbit", int'(curbit), int'(es[1]));
          check("rx_active", int'(rx_active), int'(es[0]));
        end
      end
    end
  end

  function automatic int sat(input int k);
    return (k < 0) ? 0 : samp[k];
  endfunction

  function automatic int fval(input int n);
    return (2 * sat(n - 4) + sat(n - 3)) - (2 * sat(n) + sat(n - 1));
  endfunction

  // Window-level model: one decision per window, frame rules per window,
  // WB consecutive windows per SSP word, preceded by the reset word.
  task automatic build_expect(input logic [2:0] md, input int thr, input int nedges);
    int shv[$];
    int stv[$];
    int strv[$];
    int nwin, st, run, fm, rm, f, c, bitv, sh;
    bit listen;
    logic [WB-1:0] wd;
    listen = (md == 3'd0) || (md == 3'd3);
    nwin = 0;
    while (nwin * BP + RP + 1 <= nedges - 1) nwin++;
    st = 0;
    run = 0;
    for (int w = 0; w < nwin; w++) begin
      c = w * BP + RP;
      fm = 0;
      rm = 0;
      for (int n = c - BP + 1; n < c; n++) begin
        if (n >= 0) begin
          f = fval(n);
          if (f > 0) begin
            if (f > fm) fm = f;
          end else if (f < rm) rm = f;
        end
      end
      bitv = ((fm > thr) && (rm < -thr)) ? 1 : 0;
      sh = 0;
      if (!listen) st = 0;
      else if (st == 0) begin
        if (bitv == 1) begin
          st = 1;
          run = 0;
          sh = 1;
        end
      end else begin
        sh = bitv;
        if (bitv == 1) run = 0;
        else begin
          run++;
          if (run == EOFW) st = 0;
        end
      end
      exp_stat.push_back({bitv[0], st[0]});
      shv.push_back(sh);
      stv.push_back(st);
      strv.push_back(fm - rm);
    end
    for (int j = 0; j * WCYC + BP * (WB - 1) + BP / 2 <= nedges - 1; j++) begin
      wd = '0;
      if (j > 0) begin
        for (int k = 0; k < WB; k++) wd[WB-1-k] = shv[(j-1)*WB + k][0];
`ifdef HF_RX_STRENGTH_EN
        if (stv[(j-1)*WB + WB - 1] == 0)
          wd = WB'(strv[(j-1)*WB + WB - 1] >> (ADC_W + 3 - WB));
`endif
      end
      exp_words.push_back(wd);
    end
  endtask

  task automatic gen(input int nedges, input logic [63:0] mask, input int amp,
                     input int off, input int noise);
    int v;
    for (int n = 0; n < nedges; n++) begin
      v = 128;
      if (mask[n / BP]) v += (((n + off) % BP) < BP / 2) ? amp : -amp;
      if (noise > 0) v += int'($urandom_range(0, 2 * noise)) - noise;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      samp[n] = v;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_curbit"}, int'(curbit), 0);
    check({tag, "_rx_active"}, int'(rx_active), 0);
    check({tag, "_ssp_clk"}, int'(ssp_clk), 0);
    check({tag, "_ssp_frame"}, int'(ssp_frame), 0);
    check({tag, "_ssp_din"}, int'(ssp_din), 0);
  endtask

  task automatic run_test(input string nm, input logic [2:0] md, input int thr,
                          input int nedges, input int dmode);
    logic ep;
    $display("test %s mode=%0d thr=%0d edges=%0d", nm, md, thr, nedges);
    nrst = 1'b0;
    repeat (5) begin
      @(posedge osc_clk);
      mode = md;
      threshold = 8'(thr);
      adc_d = 8'd128;
    end
    #1;
    check_zero_outputs("reset");
    build_expect(md, thr, nedges);
    for (int n = 0; n < nedges; n++) begin
      @(posedge osc_clk);
      nrst = 1'b1;
      adc_d = 8'(samp[n]);
      ssp_dout = (dmode == 1) ? 1'((n / 64) % 2) : 1'($urandom_range(0, 1));
      #1;
      ep = ((md == 3'd4) && !exp_modq) || (md == 3'd3);
      check("pwr_hi_high", int'(pwr_hi), int'(ep));
      @(negedge osc_clk);
      #1;
      check("pwr_hi_low", int'(pwr_hi), 0);
    end
    @(posedge osc_clk);
    nrst = 1'b0;
    @(negedge osc_clk);
    #1;
    check_zero_outputs("post_reset");
    @(posedge osc_clk);
    #1;
    check("words_left", exp_words.size(), 0);
    check("status_left", exp_stat.size(), 0);
    exp_words.delete();
    exp_stat.delete();
  endtask

  initial begin
    int mlist[5];
    logic [2:0] md;
    mlist = '{0, 3, 4, 1, 7};
    gen(512, 64'h0, 0, 0, 0);
    run_test("const128", 3'd3, 20, 512, 0);
    gen(512, '1, 30, 10, 0);
    run_test("square_full", 3'd3, 20, 512, 0);
    gen(768, 64'hF, 30, 10, 0);
    run_test("square_then_eof", 3'd3, 20, 768, 0);
    gen(512, '1, 30, 10, 0);
    run_test("thr40_amp30", 3'd3, 40, 512, 0);
    gen(512, '1, 10, 10, 0);
    run_test("thr40_amp10", 3'd3, 40, 512, 0);
    gen(512, '1, 60, 10, 0);
    run_test("thr255", 3'd3, 255, 512, 0);
    gen(512, 64'h0, 0, 0, 1);
    run_test("thr0_noise", 3'd3, 0, 512, 0);
    gen(512, '1, 30, 10, 0);
    run_test("reader_mod", 3'd4, 20, 512, 1);
    run_test("sniffer", 3'd0, 20, 512, 0);
    run_test("tagsim_mod", 3'd2, 20, 512, 0);
    gen(70, '1, 30, 10, 0);
    run_test("reset_midframe", 3'd3, 20, 70, 0);
    for (int t = 0; t < 8; t++) begin
      md = 3'(mlist[$urandom_range(0, 4)]);
      gen(640, {$urandom, $urandom}, int'($urandom_range(0, 60)),
          int'($urandom_range(0, BP - 1)), int'($urandom_range(0, 3)));
      run_test("random", md, int'($urandom_range(0, 80)),
               int'($urandom_range(100, 640)), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
